pipeline_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 16-bit five-stage core. It sits beside the Execute stage and decides, every cycle, whether each pipeline register advances, holds, or is bubbled/flushed. It resolves load-use hazards, redirects fetch on taken jumps using a latched compare-flag register, freezes the pipe while the memory stage is busy, and halts the core on a memory timeout. Saturating stall and flush counters are exposed for debug.

---
 rtl/pipe_pkg.sv | 58 +++++
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, the per-cycle
// action encoding and the instruction decode helpers.
package pipe_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_ADDI   = 4'h3;
    localparam logic [3:0] OP_SHLLI  = 4'h4;
    localparam logic [3:0] OP_SHRLI  = 4'h5;
    localparam logic [3:0] OP_JUMP   = 4'h6;
    localparam logic [3:0] OP_JUMPL  = 4'h7;
    localparam logic [3:0] OP_JUMPG  = 4'h8;
    localparam logic [3:0] OP_JUMPE  = 4'h9;
    localparam logic [3:0] OP_JUMPNE = 4'hA;
    localparam logic [3:0] OP_CMP    = 4'hB;
    localparam logic [3:0] OP_LOAD   = 4'hC;
    localparam logic [3:0] OP_LOADI  = 4'hD;
    localparam logic [3:0] OP_STORE  = 4'hE;
    localparam logic [3:0] OP_MOV    = 4'hF;

    // Listed in increasing priority; the value is what ctl_state reports.
    typedef enum logic [2:0] {
        ACT_RUN      = 3'd0,
        ACT_LOAD_USE = 3'd1,
        ACT_FLUSH    = 3'd2,
        ACT_MEM_WAIT = 3'd3,
        ACT_HALT     = 3'd4
    } action_e;

    // Returns {uses_src1, uses_src2} for an opcode in Decode.
    function automatic logic [1:0] src_use(input logic [3:0] op);
        logic [1:0] u;
        u = 2'b00;
        case (op)
            OP_SUB, OP_ADD, OP_CMP, OP_STORE:                 u = 2'b11;
            OP_ADDI, OP_SHLLI, OP_SHRLI, OP_LOAD, OP_MOV:     u = 2'b10;
            default:                                          u = 2'b00;
        endcase
        return u;
    endfunction

    function automatic logic jump_taken(input logic [3:0] op, input logic zf,
                                        input logic gf, input logic lf);
        logic t;
        t = 1'b0;
        case (op)
            OP_JUMP:   t = 1'b1;
            OP_JUMPL:  t = lf;
            OP_JUMPG:  t = gf;
            OP_JUMPE:  t = zf;
            OP_JUMPNE: t = ~zf;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-cycle pipeline sequencer: picks one action (RUN/LOAD_USE/FLUSH/MEM_WAIT/HALT)
// and drives the stage enables, flush and bubble controls from it.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int REGW        = 5,
    parameter int CNTW        = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  id_opcode,
    input  logic [REGW-1:0] id_src1,
    input  logic [REGW-1:0] id_src2,
    input  logic [OPW-1:0]  ex_opcode,
    input  logic [REGW-1:0] ex_dest,
    input  logic            ex_zf,
    input  logic            ex_gf,
    input  logic            ex_lf,
    input  logic            mem_busy,
    output logic            pc_we,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            if_id_flush,
    output logic            id_ex_bubble,
    output logic            pc_sel_target,
    output logic            halted,
    output logic [2:0]      ctl_state,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    localparam int WAITW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(MEM_TIMEOUT - 1);
    localparam logic [WAITW-1:0] WAIT_MAX  = WAITW'(MEM_TIMEOUT);

    logic             zf_q, gf_q, lf_q;
    logic             zf_d, gf_d, lf_d;
    logic [WAITW-1:0] wait_cnt_q, wait_cnt_d;
    logic             halted_q, halted_d;
    action_e          ctl_state_q;
    action_e          action;

    logic [1:0]       id_use;
    logic             src_hit;
    logic             load_use;
    logic             taken;
    logic             stall_inc;
    logic             flush_inc;

    // Hazard detection against the instruction currently in Execute.
    always_comb begin
        id_use   = src_use(id_opcode);
        src_hit  = (id_use[1] && (id_src1 == ex_dest)) ||
                   (id_use[0] && (id_src2 == ex_dest));
        load_use = (ex_opcode == OP_LOAD) && src_hit;
        taken    = jump_taken(ex_opcode, zf_q, gf_q, lf_q);
    end

    always_comb begin
        action = ACT_RUN;
        if (halted_q) begin
            action = ACT_HALT;
        end else if (mem_busy) begin
            action = ACT_MEM_WAIT;
        end else if (taken) begin
            action = ACT_FLUSH;
        end else if (load_use) begin
            action = ACT_LOAD_USE;
        end
    end

    // While reset is held the pipe is frozen and both front registers load NOPs.
    always_comb begin
        pc_we         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        pc_sel_target = 1'b0;
        case (action)
            ACT_HALT, ACT_MEM_WAIT: begin
                pc_we     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end
            ACT_FLUSH: begin
                pc_sel_target = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
            end
            ACT_LOAD_USE: begin
                pc_we        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
            end
        endcase
        if (!rst_n) begin
            pc_we         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            pc_sel_target = 1'b0;
        end
    end

    always_comb begin
        zf_d = zf_q;
        gf_d = gf_q;
        lf_d = lf_q;
        if ((ex_opcode == OP_CMP) && ex_mem_en) begin
            zf_d = ex_zf;
            gf_d = ex_gf;
            lf_d = ex_lf;
        end
        wait_cnt_d = '0;
        if (mem_busy) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        halted_d = halted_q || (mem_busy && (wait_cnt_q == WAIT_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q        <= 1'b0;
            gf_q        <= 1'b0;
            lf_q        <= 1'b0;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            ctl_state_q <= ACT_RUN;
        end else begin
            zf_q        <= zf_d;
            gf_q        <= gf_d;
            lf_q        <= lf_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            ctl_state_q <= action;
        end
    end

    assign stall_inc = (action == ACT_LOAD_USE) || (action == ACT_MEM_WAIT);
    assign flush_inc = (action == ACT_FLUSH);

    sat_counter #(.WIDTH(CNTW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNTW)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );

    assign halted    = halted_q;
    assign ctl_state = ctl_state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic,
// each cycle's expected outputs queued by the driver and checked by a monitor.
module tb_pipeline_hazard_ctrl;

    localparam int OPW   = 4;
    localparam int REGW  = 5;
    localparam int CNTW  = 4;
    localparam int MT    = 4;
    localparam int EXP_W = 11 + 2 * CNTW;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic            clk;
    logic            rst_n;
    logic [OPW-1:0]  id_opcode;
    logic [REGW-1:0] id_src1, id_src2;
    logic [OPW-1:0]  ex_opcode;
    logic [REGW-1:0] ex_dest;
    logic            ex_zf, ex_gf, ex_lf;
    logic            mem_busy;
    logic            pc_we, if_id_en, id_ex_en, ex_mem_en;
    logic            if_id_flush, id_ex_bubble, pc_sel_target, halted;
    logic [2:0]      ctl_state;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(
        .OPW(OPW), .REGW(REGW), .CNTW(CNTW), .MEM_TIMEOUT(MT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_src1(id_src1), .id_src2(id_src2),
        .ex_opcode(ex_opcode), .ex_dest(ex_dest),
        .ex_zf(ex_zf), .ex_gf(ex_gf), .ex_lf(ex_lf),
        .mem_busy(mem_busy),
        .pc_we(pc_we), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .pc_sel_target(pc_sel_target), .halted(halted), .ctl_state(ctl_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int m_zf, m_gf, m_lf, m_wait, m_halt, m_ctl, m_stall, m_flush;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [EXP_W-1:0] exp_q[$];
    int               tag_q[$];

    function automatic int uses1(input int op);
        return (op == 1 || op == 2 || op == 11 || op == 14 ||
                op == 3 || op == 4 || op == 5 || op == 12 || op == 15) ? 1 : 0;
    endfunction

    function automatic int uses2(input int op);
        return (op == 1 || op == 2 || op == 11 || op == 14) ? 1 : 0;
    endfunction

    function automatic int is_taken(input int op);
        case (op)
            6:       return 1;
            7:       return m_lf;
            8:       return m_gf;
            9:       return m_zf;
            10:      return (m_zf == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input int rst, input int idop, input int s1, input int s2,
                         input int exop, input int dst, input int zf, input int gf,
                         input int lf, input int busy);
        int en_pc, en_ifid, en_idex, en_exmem, fl, bub, sel, act;
        @(posedge clk);
        #1;
        rst_n     = (rst != 0);
        id_opcode = OPW'(idop);
        id_src1   = REGW'(s1);
        id_src2   = REGW'(s2);
        ex_opcode = OPW'(exop);
        ex_dest   = REGW'(dst);
        ex_zf     = (zf != 0);
        ex_gf     = (gf != 0);
        ex_lf     = (lf != 0);
        mem_busy  = (busy != 0);
        if (rst == 0) begin
            m_zf = 0; m_gf = 0; m_lf = 0; m_wait = 0; m_halt = 0;
            m_ctl = 0; m_stall = 0; m_flush = 0;
            en_pc = 0; en_ifid = 0; en_idex = 0; en_exmem = 0; fl = 1; bub = 1; sel = 0;
            act = 0;
        end else begin
            if (m_halt != 0) act = 4;
            else if (busy != 0) act = 3;
            else if (is_taken(exop) != 0) act = 2;
            else if (exop == 12 && ((uses1(idop) != 0 && s1 == dst) ||
                                    (uses2(idop) != 0 && s2 == dst))) act = 1;
            else act = 0;
            en_pc = 1; en_ifid = 1; en_idex = 1; en_exmem = 1; fl = 0; bub = 0; sel = 0;
            if (act >= 3) begin
                en_pc = 0; en_ifid = 0; en_idex = 0; en_exmem = 0;
            end else if (act == 2) begin
                fl = 1; bub = 1; sel = 1;
            end else if (act == 1) begin
                en_pc = 0; en_ifid = 0; bub = 1;
            end
        end
        exp_q.push_back({en_pc[0], en_ifid[0], en_idex[0], en_exmem[0], fl[0], bub[0],
                         sel[0], m_halt[0], 3'(m_ctl), CNTW'(m_stall), CNTW'(m_flush)});
        tag_q.push_back(cyc);
        cyc++;
        // state the next clock edge will produce
        if (rst != 0) begin
            if (exop == 11 && en_exmem != 0) begin
                m_zf = zf; m_gf = gf; m_lf = lf;
            end
            if ((act == 1 || act == 3) && m_stall < CMAX) m_stall++;
            if (act == 2 && m_flush < CMAX) m_flush++;
            m_wait = (busy != 0) ? m_wait + 1 : 0;
            if (m_wait >= MT) m_halt = 1;
            m_ctl = act;
        end
    endtask

    task automatic run(input int idop, input int s1, input int s2, input int exop,
                       input int dst, input int zf, input int gf, input int lf,
                       input int busy);
        drive(1, idop, s1, s2, exop, dst, zf, gf, lf, busy);
    endtask

    task automatic rst_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [EXP_W-1:0] act_vec;
    assign act_vec = {pc_we, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble,
                      pc_sel_target, halted, ctl_state, stall_cnt, flush_cnt};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            int t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act_vec !== e) begin
                failures++;
                $display("FAIL outputs cycle=%0d got=%h expected=%h (en/fl/bub/sel/halt/ctl/stall/flush)",
                         t, act_vec, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        id_opcode = '0; id_src1 = '0; id_src2 = '0;
        ex_opcode = '0; ex_dest = '0;
        ex_zf = 1'b0; ex_gf = 1'b0; ex_lf = 1'b0; mem_busy = 1'b0;

        rst_cycle();
        rst_cycle();
        // load-use: one stall cycle then RUN
        run(2, 2, 0, 12, 2, 0, 0, 0, 0);
        run(2, 2, 0, 2, 2, 0, 0, 0, 0);
        // MOV reads src1 only: no stall on src2 match
        run(15, 1, 3, 12, 3, 0, 0, 0, 0);
        // CMP 3 vs 5 sets lf, then JUMPL taken
        run(0, 0, 0, 11, 0, 0, 0, 1, 0);
        run(0, 0, 0, 7, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // CMP equal then JUMPNE not taken
        run(0, 0, 0, 11, 0, 1, 0, 0, 0);
        run(0, 0, 0, 10, 0, 0, 0, 0, 0);
        run(0, 0, 0, 9, 0, 0, 0, 0, 0);
        // JUMP held through three busy cycles, then FLUSH
        for (int i = 0; i < 3; i++) run(0, 0, 0, 6, 0, 0, 0, 0, 1);
        run(0, 0, 0, 6, 0, 0, 0, 0, 0);
        // CMP during busy must not load flags
        run(0, 0, 0, 11, 0, 0, 1, 0, 1);
        run(0, 0, 0, 8, 0, 0, 0, 0, 0);
        // taken jump with a matching Decode source: FLUSH, no stall
        run(2, 4, 4, 6, 4, 0, 0, 0, 0);
        // timeout halt, sticky, then reset
        for (int i = 0; i < MT; i++) run(0, 0, 0, 0, 0, 0, 0, 0, 1);
        run(2, 1, 1, 12, 1, 0, 0, 0, 0);
        run(0, 0, 0, 6, 0, 0, 0, 0, 0);
        rst_cycle();
        run(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // counter saturation
        for (int i = 0; i < CMAX + 3; i++) run(14, 0, 7, 12, 7, 0, 0, 0, 0);
        for (int i = 0; i < CMAX + 3; i++) run(0, 0, 0, 6, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 149) == 0) ? 0 : 1,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? 1 : 0);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
